// File: rtl/tpu_pkg.sv
// Shared types for the systolic-array datapath blocks.
// Lane width, accumulator type and the result collector state encoding.
package tpu_pkg;

    localparam int LANE_W = 16;

    typedef logic signed [LANE_W-1:0] acc_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } collector_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; pointers carry one extra wrap bit so full and
// empty fall out of a pointer compare. The caller never pushes into a full FIFO without a pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointers alone, and the consumer masks the head while empty.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/output_row_collector.sv
// Captures fully-valid result rows from the deskew stage, buffers them and
// writes them to result memory at sequential addresses, reporting done/errors.
module output_row_collector
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     num_rows,
    input  logic [N*LANE_W-1:0]   in_data,
    input  logic [N-1:0]          in_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*LANE_W-1:0]   out_data,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err_misalign,
    output logic                  err_overflow
);

    collector_state_t    r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_num;
    logic [ADDR_W-1:0]   r_acc_cnt;
    logic [ADDR_W-1:0]   r_wr_cnt;
    logic                r_done;
    logic                r_err_misalign;
    logic                r_err_overflow;

    logic                w_run;
    logic                w_all_valid;
    logic                w_want_push;
    logic                w_push;
    logic                w_pop;
    logic                w_overflow;
    logic                w_misalign;
    logic                w_clr;
    logic                w_last_row;
    logic                w_full;
    logic                w_empty;
    logic [N*LANE_W-1:0] w_head;

    assign w_run       = (r_state == RUN);
    assign w_all_valid = &in_valid;
    assign w_clr       = (r_state == IDLE) && start;

    // Surplus rows beyond the programmed count are dropped without any flag.
    assign w_want_push = w_run && w_all_valid && (r_acc_cnt != r_num);
    assign w_pop       = !w_empty && out_ready;
    assign w_push      = w_want_push && (!w_full || w_pop);
    assign w_overflow  = w_want_push && w_full && !w_pop;
    assign w_misalign  = w_run && (|in_valid) && !w_all_valid;
    assign w_last_row  = (r_wr_cnt == r_num - ADDR_W'(1));

    sync_fifo #(
        .WIDTH (N*LANE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (in_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_base         <= '0;
            r_num          <= '0;
            r_acc_cnt      <= '0;
            r_wr_cnt       <= '0;
            r_done         <= 1'b0;
            r_err_misalign <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base         <= base_addr;
                        r_num          <= num_rows;
                        r_acc_cnt      <= '0;
                        r_wr_cnt       <= '0;
                        r_err_misalign <= 1'b0;
                        r_err_overflow <= 1'b0;
                        // An empty job completes immediately without entering RUN.
                        if (num_rows == '0) r_done  <= 1'b1;
                        else                r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_misalign) r_err_misalign <= 1'b1;
                    if (w_overflow) r_err_overflow <= 1'b1;
                    if (w_push)     r_acc_cnt      <= r_acc_cnt + 1'b1;
                    if (w_pop) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                        if (w_last_row) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid    = !w_empty;
    assign out_data     = w_empty ? '0 : w_head;
    assign out_addr     = r_base + r_wr_cnt;
    assign out_last     = !w_empty && w_run && w_last_row;
    assign busy         = w_run;
    assign done         = r_done;
    assign err_misalign = r_err_misalign;
    assign err_overflow = r_err_overflow;

endmodule
